// File: rtl/rv_isa_pkg.sv
// Shared RV64I encoding definitions used by the instruction loader and the
// core's control decoder.
//   OPCODE_W        : width of the major opcode field
//   OP_*            : major opcodes of the supported instruction classes
//   instr_class_t   : command class code carried on the loader command bus
//   loader_state_t  : loader FSM state, exported for debug visibility
package rv_isa_pkg;

  localparam int OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SD  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;

  // Codes 5..7 are deliberately left out: they are the illegal classes.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_IMM = 3'd1,
    CLS_LD  = 3'd2,
    CLS_SD  = 3'd3,
    CLS_BEQ = 3'd4
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Command bus from the boot/test host into the instruction loader.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The master holds every cmd_* field stable while
// cmd_valid is high and not yet accepted; cmd_ready does not depend on
// cmd_valid.
//   master : host side (drives fields, valid, last; samples ready)
//   slave  : loader side
interface instr_loader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_class;
  logic [2:0] cmd_funct3;
  logic [6:0] cmd_funct7;
  logic [4:0] cmd_rd;
  logic [4:0] cmd_rs1;
  logic [4:0] cmd_rs2;
  logic [12:0] cmd_imm;
  logic       cmd_last;

  modport master (
    output cmd_valid, cmd_class, cmd_funct3, cmd_funct7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_class, cmd_funct3, cmd_funct7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/instr_encode.sv
// Combinational RV64I encoder: class + fields -> 32-bit instruction word.
//   cls, f3, f7, rd, rs1, rs2, imm : command fields
//   word     : encoded instruction (0 for an illegal class)
//   illegal  : class code is not one of R/IMM/LD/SD/BEQ
//   misalign : BEQ offset has bit 0 set (bit 0 is not encodable and is dropped)
module instr_encode
  import rv_isa_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        misalign
);

  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (instr_class_t'(cls))
      CLS_R:   word = {f7, rs2, rs1, f3, rd, OP_R};
      CLS_IMM: word = {imm[11:0], rs1, f3, rd, OP_IMM};
      CLS_LD:  word = {imm[11:0], rs1, f3, rd, OP_LD};
      CLS_SD:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_SD};
      CLS_BEQ: begin
        word     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BEQ};
        misalign = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction encoder/loader. Accepts field-level commands,
// encodes them and writes the words to consecutive instruction-memory
// addresses starting at a programmable base.
//   clk, rst_n        : clock, async active-low reset
//   start, base_addr  : begin a session (IDLE/DONE only) at base_addr & ~3
//   cmd               : command bus (slave side)
//   imem_we/addr/wdata: registered instruction-memory write port
//   done              : one-cycle pulse, one cycle after the session's last write
//   count             : words written in the current session
//   err_illegal/align/ovf : sticky error flags, cleared by start
//   state_dbg         : current FSM state
module instr_loader
  import rv_isa_pkg::*;
#(
  parameter  int IMEM_AW = 10,
  parameter  int DEPTH   = 256,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] base_addr,
  instr_loader_if.slave      cmd,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               err_illegal,
  output logic               err_align,
  output logic               err_ovf,
  output loader_state_t      state_dbg
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_t      state;
  logic [IMEM_AW-1:0] ptr;
  logic               accept;
  logic [31:0]        enc_word;
  logic               enc_illegal;
  logic               enc_misalign;

  assign cmd.cmd_ready = (state == ST_LOAD) && (count < DEPTH_C);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign state_dbg     = state;

  instr_encode u_encode (
    .cls      (cmd.cmd_class),
    .f3       (cmd.cmd_funct3),
    .f7       (cmd.cmd_funct7),
    .rd       (cmd.cmd_rd),
    .rs1      (cmd.cmd_rs1),
    .rs2      (cmd.cmd_rs2),
    .imm      (cmd.cmd_imm),
    .word     (enc_word),
    .illegal  (enc_illegal),
    .misalign (enc_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      count       <= '0;
      err_illegal <= 1'b0;
      err_align   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_LOAD;
            ptr         <= {base_addr[IMEM_AW-1:2], 2'b00};
            count       <= '0;
            err_illegal <= 1'b0;
            err_align   <= 1'b0;
            err_ovf     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              err_illegal <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + IMEM_AW'(4);  // wraps silently
              count      <= count + CNT_W'(1);
              if (enc_misalign) err_align <= 1'b1;
            end
            // A last command ends the session normally; otherwise filling
            // the last slot means the host had more to send than fits.
            if (cmd.cmd_last) begin
              state <= ST_FLUSH;
            end else if (!enc_illegal && (count == DEPTH_C - CNT_W'(1))) begin
              state   <= ST_FLUSH;
              err_ovf <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // The final write is visible on the port during this cycle.
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;
  import rv_isa_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = CW + AW + 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic [CW-1:0] count;
  logic          err_illegal, err_align, err_ovf;
  loader_state_t state_dbg;

  instr_loader_if bus ();

  instr_loader #(.IMEM_AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .cmd         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .done        (done),
    .count       (count),
    .err_illegal (err_illegal),
    .err_align   (err_align),
    .err_ovf     (err_ovf),
    .state_dbg   (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected writes: {count after write, address, data}
  logic [EW-1:0]    exp_q[$];
  logic [AW+31:0]   wr_log[$];
  int               wr_cyc[$];
  int m_ptr, m_count;
  bit m_ill, m_aln, m_ovf;

  // Field placement by arithmetic (bit position = multiplier).
  function automatic logic [31:0] model_encode(input int cls, f3, f7, rd, rs1, rs2, imm);
    int unsigned w;
    int unsigned lo12;
    w    = (f3 << 12) | (rs1 << 15);
    lo12 = imm % 4096;
    case (cls)
      0: w = w | 'h33 | (rd << 7) | (rs2 << 20) | (f7 << 25);
      1: w = w | 'h13 | (rd << 7) | (lo12 << 20);
      2: w = w | 'h03 | (rd << 7) | (lo12 << 20);
      3: w = w | 'h23 | ((lo12 % 32) << 7) | (rs2 << 20) | ((lo12 / 32) << 25);
      4: w = w | 'h63 | (((imm / 2048) % 2) << 7) | (((imm / 2) % 16) << 8)
               | (rs2 << 20) | (((imm / 32) % 64) << 25) | (((imm / 4096) % 2) << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic model_accept(input int cls, f3, f7, rd, rs1, rs2, imm, input bit last);
    if (cls > 4) begin
      m_ill = 1'b1;
    end else begin
      m_count++;
      exp_q.push_back({CW'(m_count), AW'(m_ptr), model_encode(cls, f3, f7, rd, rs1, rs2, imm)});
      m_ptr = (m_ptr + 4) % (1 << AW);
      if (cls == 4 && (imm % 2) == 1) m_aln = 1'b1;
      if (!last && m_count == DEPTH) m_ovf = 1'b1;
    end
  endtask

  // ---------------- write monitor / scoreboard ----------------
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_log.push_back({imem_addr, imem_wdata});
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr",  imem_addr,  mon_e[AW+31:32]);
        check("wr_data",  imem_wdata, mon_e[31:0]);
        check("wr_count", count,      mon_e[EW-1:AW+32]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input int base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    @(posedge clk);
    #1 start = 1'b0;
    m_ptr   = (base / 4) * 4;
    m_count = 0;
    m_ill   = 1'b0;
    m_aln   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic start_pulse_ignored(input int base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input int cls, f3, f7, rd, rs1, rs2, imm, input bit last,
                      input int bound, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_class  = cls[2:0];
    bus.cmd_funct3 = f3[2:0];
    bus.cmd_funct7 = f7[6:0];
    bus.cmd_rd     = rd[4:0];
    bus.cmd_rs1    = rs1[4:0];
    bus.cmd_rs2    = rs2[4:0];
    bus.cmd_imm    = imm[12:0];
    bus.cmd_last   = last;
    for (int i = 0; i < bound; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.cmd_ready) begin
        model_accept(cls, f3, f7, rd, rs1, rs2, imm, last);
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(posedge clk);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last command.
  task automatic end_session(input string tag);
    @(negedge clk);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_state"}, state_dbg, ST_DONE);
    check({tag, "_count"}, count, m_count);
    check({tag, "_err_illegal"}, err_illegal, m_ill);
    check({tag, "_err_align"}, err_align, m_aln);
    check({tag, "_err_ovf"}, err_ovf, m_ovf);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_ready"}, bus.cmd_ready, 0);
    check({tag, "_errs"}, {err_illegal, err_align, err_ovf}, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int n0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_class  = '0;
    bus.cmd_funct3 = '0;
    bus.cmd_funct7 = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm    = '0;
    bus.cmd_last   = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single R command from base 0.
    wr_log.delete(); wr_cyc.delete();
    do_start(0);
    @(negedge clk);
    check("load_ready", bus.cmd_ready, 1);
    send(0, 0, 0, 3, 1, 2, 0, 1'b1, 4, acc);
    check("r_acc", acc, 1);
    end_session("r");
    check("r_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) check("r_word", wr_log[0], {10'h000, 32'h002081B3});

    // Four back-to-back classes from 0x100.
    wr_log.delete(); wr_cyc.delete();
    do_start('h100);
    send(1, 0, 0, 5, 0, 0, 10,      1'b0, 4, acc); check("b2b_acc0", acc, 1);
    send(2, 3, 0, 6, 2, 0, 8,       1'b0, 4, acc); check("b2b_acc1", acc, 1);
    send(3, 3, 0, 0, 2, 6, 16,      1'b0, 4, acc); check("b2b_acc2", acc, 1);
    send(4, 0, 0, 0, 1, 2, 'h1FF8,  1'b1, 4, acc); check("b2b_acc3", acc, 1);
    end_session("b2b");
    check("b2b_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("b2b_imm", wr_log[0], {10'h100, 32'h00A00293});
      check("b2b_ld",  wr_log[1], {10'h104, 32'h00813303});
      check("b2b_sd",  wr_log[2], {10'h108, 32'h00613823});
      check("b2b_beq", wr_log[3], {10'h10C, 32'hFE208CE3});
      for (int i = 1; i < 4; i++) check("b2b_consec", wr_cyc[i] - wr_cyc[0], i);
    end

    // Illegal class between two valid commands.
    wr_log.delete(); wr_cyc.delete();
    do_start('h200);
    send(1, 0, 0, 1, 2, 0, 5, 1'b0, 4, acc);
    send(6, 0, 0, 1, 2, 0, 5, 1'b0, 4, acc); check("ill_acc", acc, 1);
    send(1, 0, 0, 3, 4, 0, 7, 1'b1, 4, acc);
    end_session("ill");
    check("ill_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) check("ill_addr1", wr_log[1][AW+31:32], 'h204);
    do_start('h000);
    @(negedge clk);
    check("ill_cleared", err_illegal, 0);
    send(0, 1, 0, 1, 1, 1, 0, 1'b1, 4, acc);
    end_session("after_ill");

    // Overflow: more commands offered than DEPTH.
    wr_log.delete(); wr_cyc.delete();
    do_start('h020);
    for (int k = 0; k < DEPTH; k++) begin
      send(1, 0, 0, k, k, 0, k, 1'b0, 4, acc);
      check("ovf_acc", acc, 1);
    end
    @(negedge clk);
    check("ovf_ready_drop", bus.cmd_ready, 0);
    check("ovf_done_early", done, 0);
    @(negedge clk);
    check("ovf_done", done, 1);
    check("ovf_flag", err_ovf, 1);
    check("ovf_count", count, DEPTH);
    for (int k = 0; k < 2; k++) begin
      send(1, 0, 0, 1, 1, 0, 1, 1'b0, 3, acc);
      check("ovf_refused", acc, 0);
    end
    check("ovf_nwr", wr_log.size(), DEPTH);

    // Pointer wrap at the top of the address space.
    wr_log.delete(); wr_cyc.delete();
    do_start('h3FC);
    send(1, 0, 0, 1, 0, 0, 1, 1'b0, 4, acc);
    send(1, 0, 0, 2, 0, 0, 2, 1'b1, 4, acc);
    end_session("wrap");
    check("wrap_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("wrap_a0", wr_log[0][AW+31:32], 'h3FC);
      check("wrap_a1", wr_log[1][AW+31:32], 'h000);
    end

    // Reset asserted right after an accept drops the pending write.
    do_start('h040);
    send(1, 0, 0, 9, 9, 0, 9, 1'b0, 4, acc);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    wr_log.delete(); wr_cyc.delete();
    do_start('h080);
    send(0, 0, 'h20, 7, 8, 9, 0, 1'b1, 4, acc);
    end_session("postrst");
    if (wr_log.size() == 1) check("postrst_addr", wr_log[0][AW+31:32], 'h080);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      int len;
      len = $urandom_range(1, DEPTH - 2);
      n0 = wr_log.size();
      do_start($urandom_range(0, (1 << AW) - 1));
      for (int k = 0; k < len; k++) begin
        int cls;
        cls = ($urandom_range(0, 9) > 7) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        if (k == 1 && (s % 4) == 0) start_pulse_ignored($urandom_range(0, (1 << AW) - 1));
        send(cls, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 8191),
             (k == len - 1), 4, acc);
        check("rnd_acc", acc, 1);
      end
      end_session("rnd");
      check("rnd_nwr", wr_log.size() - n0, m_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential instruction encoder and loader for the single-cycle RISC-V core. It is the producing end of the opcode/field contract that the core's control decoder consumes. It accepts field-level instruction commands over a valid/ready handshake and encodes them into 32-bit RV64I words for the R-format, OP-IMM, ld, sd and beq classes. It writes the words sequentially into instruction memory from a programmable base address. It sits between the test/boot host and the instruction-memory write port, and runs before the core is released from reset.

## Interface
- `IMEM_AW`, default 10: instruction-memory byte-address width.
- `DEPTH`, default 256: maximum number of words loaded per session.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a session; honoured only in IDLE or DONE.
- `base_addr` in IMEM_AW: byte address of the first word; sampled on `start`; bits [1:0] are ignored (treated as 0).
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_class` in 3: instruction class. 0 = R, 1 = IMM, 2 = LD, 3 = SD, 4 = BEQ, 5–7 = illegal.
- `cmd_funct3` in 3, `cmd_funct7` in 7: function fields. `cmd_funct7` is used by R only.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 5 each: register fields.
- `cmd_imm` in 13: immediate. Bits [11:0] are used by IMM/LD/SD. The full 13-bit byte offset is used by BEQ.
- `cmd_last` in 1: marks the final command of the session.
- `imem_we` out 1, `imem_addr` out IMEM_AW, `imem_wdata` out 32: instruction-memory write port.
- `done` out 1: one-cycle pulse when a session ends.
- `count` out $clog2(DEPTH+1): number of words written in the current session.
- `err_illegal`, `err_align`, `err_ovf` out 1 each: sticky error flags; cleared on `start`.

## Operation
- The FSM has four states: IDLE, LOAD, FLUSH, DONE.
  - IDLE → LOAD on `start`. This clears `count` and the error flags and loads the write pointer with `base_addr`.
  - LOAD → FLUSH on an accepted command with `cmd_last`=1.
  - LOAD → FLUSH when `count` reaches DEPTH after a write. This also sets `err_ovf`.
  - FLUSH → DONE after the final pending write has retired. `done` pulses in this transition cycle.
  - DONE → LOAD on `start`.
- `cmd_ready` is 1 only in LOAD with `count` < DEPTH.
- Encoding by class:
  - R: {f7, rs2, rs1, f3, rd, 0110011}.
  - IMM: {imm[11:0], rs1, f3, rd, 0010011}.
  - LD: {imm[11:0], rs1, f3, rd, 0000011}.
  - SD: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
- Illegal class:
  - No write occurs and `count` is unchanged; `err_illegal` is set.
  - `cmd_last` is still honoured.
- BEQ with `cmd_imm[0]`=1:
  - The word is written with bit 0 dropped, and `err_align` is set.
- The write pointer advances by 4 per write, modulo 2^IMEM_AW; wrap-around is silent.
- `start` received while in LOAD or FLUSH is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - `cmd_ready`, `imem_we`, `done`, all `err_*` = 0;
  - `count` = 0; `imem_addr` = 0; `imem_wdata` = 0.
- Write latency is 1 cycle. A command accepted at edge N produces `imem_we`=1 with its address and data during cycle N+1, registered.
- Throughput is one command per cycle: back-to-back accepts give back-to-back writes.
- `count` increments on the same edge the write is registered, so it is visible alongside `imem_we`.
- `done` goes high exactly one cycle after the last `imem_we`. With a `cmd_last` accept at edge N, the write occurs in cycle N+1 and `done` in cycle N+2.
- When `cmd_valid` is low in LOAD, no write occurs and the pointer holds.
- If `rst_n` is asserted mid-session, everything returns immediately to reset values and a pending write is dropped.

## Structure
- Shared package `rv_isa_pkg`, used by both this block and the control decoder:
  - opcode constants: OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_BEQ = 7'b1100011;
  - `instr_class_t` enum;
  - OPCODE_W.
- Sub-module `instr_encode`: purely combinational class+fields → {word, illegal, misalign}. The top level holds the FSM, pointer, output register, count and error flags.

## Test plan
- `start`, base 0x000, then R rd=3 rs1=1 rs2=2 f3=0 f7=0 with `cmd_last` → write 0x002081B3 @ 0x000; `count`=1; `done` two cycles after the accept.
- Four back-to-back commands from base 0x100:
  - IMM rd=5 rs1=0 imm=10 → 0x00A00293 @ 0x100;
  - LD rd=6 rs1=2 f3=3 imm=8 → 0x00813303 @ 0x104;
  - SD rs1=2 rs2=6 f3=3 imm=16 → 0x00613823 @ 0x108;
  - BEQ rs1=1 rs2=2 imm=0x1FF8 (−8) → 0xFE208CE3 @ 0x10C.
  Expected: `imem_we` high on four consecutive cycles; `count`=4.
- Illegal class 6 between two valid commands → no write for it; the addresses of the valid writes stay contiguous; `err_illegal`=1 until the next `start`.
- DEPTH=4, six commands offered → exactly 4 writes; `cmd_ready` drops; `err_ovf`=1; `done` pulses.
- Base 0x3FC with IMEM_AW=10, two commands → writes at 0x3FC then 0x000.
- `rst_n` low one cycle after an accept → no `imem_we`; all outputs at reset values; a subsequent `start` works normally.
